fir_seq_ctrl: RTL and testbench

Time-multiplexed FIR sequencer: accepts one signed input sample per valid/ready handshake, then steps a single shared multiplier–accumulator across N taps, one tap per cycle. Produces one filtered output per sample on a valid/ready output port. Sits between the sample source and downstream consumers. Replaces a fully parallel N-multiplier filter where area matters more than throughput. Coefficients are held in an internal register file, writable at runtime from a configuration port.

---
 rtl/fir_seq_ctrl_if.sv | 31 +++
 rtl/fir_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_fir_seq_ctrl.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_seq_ctrl_if.sv
// Stream bundle for fir_seq_ctrl:
// signed samples in, filtered results out.
interface fir_seq_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 16
);
  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] s_data;
  logic                 m_valid;
  logic                 m_ready;
  logic signed [AW-1:0] m_data;

  modport master (
    output s_valid,
    output s_data,
    output m_ready,
    input  s_ready,
    input  m_valid,
    input  m_data
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  m_ready,
    output s_ready,
    output m_valid,
    output m_data
  );
endinterface

// File: rtl/fir_seq_ctrl.sv
// Time-multiplexed FIR: one shared MAC
// stepped across N taps per accepted sample.
module fir_seq_ctrl #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int AW = 16,
  localparam int KW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  fir_seq_ctrl_if.slave        io,
  input  logic                 coef_we,
  input  logic [KW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  output logic                 coef_err,
  output logic                 busy
);

  localparam int PW = DW + CW;
  localparam logic [KW-1:0] KLAST =
    KW'(N - 1);
  localparam logic [KW:0] NLIM =
    (KW + 1)'(N);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  state_t state_q, state_d;

  logic signed [DW-1:0] x_q [N];
  logic signed [DW-1:0] x_d [N];
  logic signed [CW-1:0] h_q [N];
  logic signed [CW-1:0] h_d [N];

  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] m_data_q, m_data_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 coef_err_q;
  logic                 coef_err_d;

  logic                 is_idle;
  logic                 coef_ok;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_ext;
  logic signed [AW-1:0] sum;

  assign is_idle    = (state_q == IDLE);
  assign io.s_ready = is_idle;
  assign io.m_valid = (state_q == OUT);
  assign io.m_data  = m_data_q;
  assign busy       = !is_idle;
  assign coef_err   = coef_err_q;

  assign coef_ok = is_idle &&
    ({1'b0, coef_addr} < NLIM);

  // Full-precision product, then wrap
  // into the accumulator width.
  assign prod = PW'(x_q[k_q]) *
                PW'(h_q[k_q]);
  assign prod_ext = AW'(prod);
  assign sum = acc_q + prod_ext;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    k_d        = k_q;
    m_data_d   = m_data_q;
    x_d        = x_q;
    h_d        = h_q;
    coef_err_d = 1'b0;

    if (coef_we) begin
      if (coef_ok) begin
        h_d[coef_addr] = coef_data;
      end else begin
        coef_err_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (io.s_valid) begin
          for (int i = N - 1; i > 0; i--)
            x_d[i] = x_q[i-1];
          x_d[0]  = io.s_data;
          acc_d   = '0;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = sum;
        k_d   = k_q + 1'b1;
        if (k_q == KLAST) begin
          m_data_d = sum;
          k_d      = '0;
          state_d  = OUT;
        end
      end
      OUT: begin
        if (io.m_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      k_q        <= '0;
      m_data_q   <= '0;
      coef_err_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        x_q[i] <= '0;
        h_q[i] <= CW'(1);
      end
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      k_q        <= k_d;
      m_data_q   <= m_data_d;
      coef_err_q <= coef_err_d;
      x_q        <= x_d;
      h_q        <= h_d;
    end
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Randomized + directed bench for fir_seq_ctrl
// against a sum-of-products reference model.
module tb_fir_seq_ctrl;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_seq_ctrl_if #(.DW(DW), .AW(AW)) io ();
  fir_seq_ctrl_if #(.DW(DW), .AW(AW)) io5 ();

  logic                 coef_we;
  logic [1:0]           coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 coef_err;
  logic                 busy;

  logic                 we5;
  logic [2:0]           addr5;
  logic signed [CW-1:0] data5;
  logic                 err5;
  logic                 busy5;

  fir_seq_ctrl #(
    .N(N), .DW(DW), .CW(CW), .AW(AW)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .io(io.slave),
    .coef_we(coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .coef_err(coef_err),
    .busy(busy)
  );

  fir_seq_ctrl #(
    .N(5), .DW(DW), .CW(CW), .AW(AW)
  ) u_dut5 (
    .clk(clk),
    .rst(rst),
    .io(io5.slave),
    .coef_we(we5),
    .coef_addr(addr5),
    .coef_data(data5),
    .coef_err(err5),
    .busy(busy5)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, exp);
    end
  endtask

  // Reference model: history of samples and
  // taps, result is a plain sum of products.
  int  mcyc = 0;
  int  acc_e = 0;
  bit  inflt = 1'b0;
  bit  merr = 1'b0;
  int  my = 0;
  int  mmd = 0;
  int  xx [N];
  int  hx [N];
  bit  m_idle;
  bit  m_mvb;
  int  m_sum;
  logic signed [AW-1:0] m_wrap;

  initial forever begin
    @(posedge clk);
    mcyc++;
    if (rst) begin
      inflt = 1'b0;
      merr  = 1'b0;
      mmd   = 0;
      acc_e = 0;
      for (int k = 0; k < N; k++) begin
        xx[k] = 0;
        hx[k] = 1;
      end
    end else begin
      m_idle = !inflt;
      m_mvb  = inflt && (mcyc - 1 - acc_e >= N);
      merr   = 1'b0;
      if (coef_we) begin
        if (m_idle && int'(coef_addr) < N)
          hx[int'(coef_addr)] = int'(coef_data);
        else
          merr = 1'b1;
      end
      if (m_idle && io.s_valid) begin
        for (int k = N - 1; k > 0; k--)
          xx[k] = xx[k-1];
        xx[0] = int'(io.s_data);
        m_sum = 0;
        for (int k = 0; k < N; k++)
          m_sum += xx[k] * hx[k];
        m_wrap = AW'(m_sum);
        my     = int'(m_wrap);
        inflt  = 1'b1;
        acc_e  = mcyc;
      end else if (m_mvb && io.m_ready) begin
        inflt = 1'b0;
      end
      if (inflt && (mcyc - acc_e == N))
        mmd = my;
    end
  end

  bit mon_en = 1'b0;
  bit mv_prev = 1'b0;
  int mv_cnt = 0;
  int got [$];
  int got5 [$];
  int acc_t [$];
  int mv_t [$];

  initial forever begin
    @(negedge clk);
    if (!rst && mon_en) begin
      chk("s_ready", int'(io.s_ready),
          int'(!inflt));
      chk("busy", int'(busy), int'(inflt));
      chk("m_valid", int'(io.m_valid),
          int'(inflt && (mcyc - acc_e >= N)));
      chk("coef_err", int'(coef_err),
          int'(merr));
      chk("m_data", int'(io.m_data), mmd);
    end
    if (!rst) begin
      if (io.s_valid && io.s_ready)
        acc_t.push_back(mcyc + 1);
      if (io.m_valid && !mv_prev)
        mv_t.push_back(mcyc);
      if (io.m_valid && io.m_ready)
        got.push_back(int'(io.m_data));
      if (io5.m_valid && io5.m_ready)
        got5.push_back(int'(io5.m_data));
      if (io.m_valid)
        mv_cnt++;
      mv_prev = io.m_valid;
    end else begin
      mv_prev = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!io.s_ready && t < 100) begin
      step();
      t++;
    end
    chk("idle_wait", int'(io.s_ready), 1);
  endtask

  task automatic send(input int d);
    wait_idle();
    io.s_valid = 1'b1;
    io.s_data  = DW'(d);
    step();
    io.s_valid = 1'b0;
  endtask

  task automatic send5(input int d);
    int t = 0;
    while (!io5.s_ready && t < 100) begin
      step();
      t++;
    end
    chk("idle5_wait", int'(io5.s_ready), 1);
    io5.s_valid = 1'b1;
    io5.s_data  = DW'(d);
    step();
    io5.s_valid = 1'b0;
  endtask

  task automatic wr(input int a,
                    input int d);
    coef_we   = 1'b1;
    coef_addr = 2'(a);
    coef_data = CW'(d);
    step();
    coef_we   = 1'b0;
  endtask

  task automatic chk_out(input string nm,
                         input int e [5],
                         input bit five);
    int n;
    n = five ? got5.size() : got.size();
    chk({nm, "_count"}, n, 5);
    for (int i = 0; i < 5; i++)
      if (i < n)
        chk($sformatf("%s_%0d", nm, i),
            five ? got5[i] : got[i], e[i]);
    if (five) got5.delete();
    else got.delete();
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  int e [5];
  int t;
  int hold0;

  initial begin
    rst = 1'b1;
    io.s_valid = 1'b0;
    io.s_data  = '0;
    io.m_ready = 1'b1;
    io5.s_valid = 1'b0;
    io5.s_data  = '0;
    io5.m_ready = 1'b1;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    we5 = 1'b0;
    addr5 = '0;
    data5 = '0;
    repeat (3) step();
    rst = 1'b0;
    mon_en = 1'b1;
    step();

    chk("rst_s_ready", int'(io.s_ready), 1);
    chk("rst_m_valid", int'(io.m_valid), 0);
    chk("rst_m_data", int'(io.m_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_coef_err", int'(coef_err), 0);
    chk("rst5_busy", int'(busy5), 0);

    // Box-car default taps
    got.delete();
    send(1);
    repeat (4) send(0);
    wait_idle();
    e = '{1, 1, 1, 1, 0};
    chk_out("boxcar", e, 1'b0);

    // Loaded taps: impulse then step
    wr(0, 1); wr(1, 2); wr(2, 2); wr(3, 1);
    send(1);
    repeat (4) send(0);
    wait_idle();
    e = '{1, 2, 2, 1, 0};
    chk_out("impulse", e, 1'b0);
    repeat (5) send(10);
    wait_idle();
    e = '{10, 30, 50, 60, 60};
    chk_out("step", e, 1'b0);

    // Write while busy must be dropped
    send(1);
    coef_we   = 1'b1;
    coef_addr = 2'd0;
    coef_data = 8'sd55;
    step();
    coef_we = 1'b0;
    chk("busy_wr_err", int'(coef_err), 1);
    step();
    chk("busy_wr_err_end", int'(coef_err), 0);
    repeat (4) send(0);
    wait_idle();
    e = '{51, 32, 12, 1, 0};
    chk_out("busy_wr", e, 1'b0);

    // Throughput with continuous input
    acc_t.delete();
    mv_t.delete();
    io.s_valid = 1'b1;
    io.s_data  = 8'sd3;
    repeat (4 * (N + 2) + 2) step();
    io.s_valid = 1'b0;
    wait_idle();
    chk("acc_count", int'(acc_t.size() >= 4), 1);
    chk("mv_count", int'(mv_t.size() >= 4), 1);
    if (acc_t.size() >= 4 && mv_t.size() >= 4) begin
      for (int i = 0; i < 3; i++)
        chk("acc_gap", acc_t[i+1] - acc_t[i], N + 2);
      for (int i = 0; i < 4; i++)
        chk("latency", mv_t[i] - acc_t[i], N);
    end
    got.delete();

    // Accumulator wrap
    for (int i = 0; i < N; i++) wr(i, 127);
    repeat (4) send(-128);
    wait_idle();
    chk("wrap_count", got.size(), 4);
    if (got.size() >= 4)
      chk("wrap", got[3], 512);
    got.delete();

    // Back-pressure
    io.m_ready = 1'b0;
    send(1);
    t = 0;
    while (!io.m_valid && t < 50) begin
      step();
      t++;
    end
    chk("bp_m_valid", int'(io.m_valid), 1);
    hold0 = int'(io.m_data);
    chk("bp_value", hold0, 16895);
    io.s_valid = 1'b1;
    io.s_data  = 8'sd7;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold", int'(io.m_data), hold0);
      chk("bp_s_ready", int'(io.s_ready), 0);
    end
    io.m_ready = 1'b1;
    step();
    step();
    io.s_valid = 1'b0;
    wait_idle();
    chk("bp_count", got.size(), 2);
    if (got.size() >= 2) begin
      chk("bp_out0", got[0], 16895);
      chk("bp_out1", got[1], -31496);
    end
    got.delete();

    // Reset in the middle of a MAC run
    send(5);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mv_cnt = 0;
    repeat (10) step();
    chk("rst_no_mv", mv_cnt, 0);
    got.delete();
    send(1);
    repeat (4) send(0);
    wait_idle();
    e = '{1, 1, 1, 1, 0};
    chk_out("post_rst", e, 1'b0);

    // Out-of-range address on a 5-tap build
    we5 = 1'b1; addr5 = 3'd5; data5 = 8'sd9;
    step();
    we5 = 1'b0;
    chk("addr5_err", int'(err5), 1);
    step();
    chk("addr5_err_end", int'(err5), 0);
    we5 = 1'b1; addr5 = 3'd7;
    step();
    we5 = 1'b0;
    chk("addr7_err", int'(err5), 1);
    we5 = 1'b1; addr5 = 3'd4; data5 = 8'sd3;
    step();
    we5 = 1'b0;
    chk("addr4_ok", int'(err5), 0);
    got5.delete();
    send5(1);
    repeat (4) send5(0);
    t = 0;
    while (!io5.s_ready && t < 100) begin
      step();
      t++;
    end
    chk("idle5_end", int'(io5.s_ready), 1);
    e = '{1, 1, 1, 1, 3};
    chk_out("tap5", e, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      io.s_valid = 1'($urandom_range(0, 1));
      io.s_data  = DW'($urandom);
      io.m_ready = ($urandom_range(0, 3) != 0);
      coef_we    = ($urandom_range(0, 7) == 0);
      coef_addr  = 2'($urandom);
      coef_data  = CW'($urandom);
      rst        = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    io.s_valid = 1'b0;
    io.m_ready = 1'b1;
    coef_we = 1'b0;
    step();
    wait_idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
